// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding load/store bridge onto a req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses without a bus cycle.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        memrd_i,
  input  logic        memw_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  state_t      state_q, state_d;
  acc_t        acc_q;
  logic [7:0]  cnt_q;
  logic        start;
  logic        timeout;
  logic        misalign;
  logic        is_b, is_h, is_w, is_u;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic        err_d;
  logic        load_en;
  logic [31:0] load_val;

  assign start   = memrd_i | memw_i;
  assign timeout = cnt_q >= 8'(TIMEOUT_CYC - 1);

  // Undefined funct3 codes (011, 110, 111) fall into the word class.
  assign is_b = acc_q.funct3[1:0] == 2'b00;
  assign is_h = acc_q.funct3[1:0] == 2'b01;
  assign is_w = acc_q.funct3[1];
  assign is_u = acc_q.funct3[2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_h & acc_q.addr[0]) |
                    (is_w & (|acc_q.addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be        = 4'b1111;
    wdata_rep = acc_q.wdata;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << acc_q.addr[1:0];
        wdata_rep = {4{acc_q.wdata[7:0]}};
      end
      is_h: begin
        be        = acc_q.addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{acc_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = bus_rdata_i[{acc_q.addr[1:0], 3'b000} +: 8];
  assign lane_h = acc_q.addr[1] ? bus_rdata_i[31:16]
                                : bus_rdata_i[15:0];

  always_comb begin
    load_ext = bus_rdata_i;
    unique case (1'b1)
      is_b:    load_ext = {{24{~is_u & lane_b[7]}}, lane_b};
      is_h:    load_ext = {{16{~is_u & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    load_en  = 1'b0;
    load_val = '0;
    unique case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (misalign || (!bus_gnt_i && timeout)) begin
          state_d = DONE;
          err_d   = 1'b1;
          load_en = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          state_d  = DONE;
          err_d    = bus_err_i;
          load_en  = ~acc_q.we | bus_err_i;
          load_val = bus_err_i ? 32'h0 : load_ext;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          load_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_o   <= err_d;
      if (state_q == IDLE && start)
        acc_q <= {memw_i, funct3_i, addr_i, wdata_i};
      if (state_q == IDLE)
        cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT)
        cnt_q <= cnt_q + 8'd1;
      if (load_en)
        rdata_o <= load_val;
    end
  end

  // Bus fields are only meaningful while the request is presented.
  assign bus_req_o   = (state_q == REQ) & ~misalign;
  assign bus_we_o    = bus_req_o & acc_q.we;
  assign bus_addr_o  = bus_req_o ? {acc_q.addr[31:2], 2'b00} : 32'h0;
  assign bus_be_o    = bus_req_o ? be : 4'b0000;
  assign bus_wdata_o = bus_req_o ? wdata_rep : 32'h0;

  assign stall_o = (state_q == IDLE & start) |
                   (state_q == REQ) |
                   (state_q == WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for
// bus error, timeout, late response, async reset and misalignment.
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memrd, memw;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o;
  logic        stall_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .memrd_i(memrd),
    .memw_i(memw),
    .funct3_i(funct3),
    .addr_i(addr),
    .wdata_i(wdata),
    .rdata_o(rdata_o),
    .stall_o(stall_o),
    .err_o(err_o),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    logic [3:0]  be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [2:0] f3, input logic we, input logic both,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] brd, input logic [3:0] be,
    input logic [31:0] ea, input logic [31:0] ewd,
    input logic [31:0] erd);
    vec_t v;
    v.f3 = f3; v.we = we; v.both = both; v.addr = a;
    v.wdata = wd; v.bus_rd = brd; v.be = be;
    v.exp_addr = ea; v.exp_wd = ewd; v.exp_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    memw = v.we; memrd = ~v.we | v.both;
    #1;
    chk($sformatf("v%0d stall_idle", i), 32'(stall_o), 1);
    step();
    memrd = 0; memw = 0;
    chk($sformatf("v%0d req", i), 32'(bus_req_o), 1);
    chk($sformatf("v%0d we", i), 32'(bus_we_o), 32'(v.we));
    chk($sformatf("v%0d addr", i), bus_addr_o, v.exp_addr);
    chk($sformatf("v%0d be", i), 32'(bus_be_o), 32'(v.be));
    if (v.we) chk($sformatf("v%0d wdata", i), bus_wdata_o, v.exp_wd);
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    chk($sformatf("v%0d req_drop", i), 32'(bus_req_o), 0);
    chk($sformatf("v%0d stall_wait", i), 32'(stall_o), 1);
    bus_rvalid = 1; bus_rdata = v.bus_rd;
    step();
    bus_rvalid = 0; bus_rdata = 0;
    chk($sformatf("v%0d stall_done", i), 32'(stall_o), 0);
    chk($sformatf("v%0d err", i), 32'(err_o), 0);
    if (!v.we) last_rd = v.exp_rd;
    chk($sformatf("v%0d rdata", i), rdata_o, last_rd);
    step();
    chk($sformatf("v%0d idle_stall", i), 32'(stall_o), 0);
  endtask

  initial begin
    int n;
    rst_n = 0; memrd = 0; memw = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = 0;

    vecs.push_back(mk(3'b000, 0, 0, 32'h103, 0, 32'h80123456, 4'b1000, 32'h100, 0, 32'hFFFFFF80));
    vecs.push_back(mk(3'b100, 0, 0, 32'h101, 0, 32'h0000F200, 4'b0010, 32'h100, 0, 32'h000000F2));
    vecs.push_back(mk(3'b001, 0, 0, 32'h42, 0, 32'h80011234, 4'b1100, 32'h40, 0, 32'hFFFF8001));
    vecs.push_back(mk(3'b101, 0, 0, 32'h40, 0, 32'h80019234, 4'b0011, 32'h40, 0, 32'h00009234));
    vecs.push_back(mk(3'b010, 0, 0, 32'h80, 0, 32'hDEADBEEF, 4'b1111, 32'h80, 0, 32'hDEADBEEF));
    vecs.push_back(mk(3'b001, 1, 0, 32'h202, 32'h1234ABCD, 0, 4'b1100, 32'h200, 32'hABCDABCD, 0));
    vecs.push_back(mk(3'b000, 1, 1, 32'h301, 32'h000000A5, 0, 4'b0010, 32'h300, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(3'b010, 1, 0, 32'h10, 32'hCAFEF00D, 0, 4'b1111, 32'h10, 32'hCAFEF00D, 0));
    vecs.push_back(mk(3'b011, 0, 0, 32'h20, 0, 32'h00000007, 4'b1111, 32'h20, 0, 32'h00000007));
    vecs.push_back(mk(3'b110, 0, 0, 32'h24, 0, 32'h89ABCDEF, 4'b1111, 32'h24, 0, 32'h89ABCDEF));
    vecs.push_back(mk(3'b000, 0, 0, 32'h100, 0, 32'h1234567F, 4'b0001, 32'h100, 0, 32'h0000007F));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(3'b001, 0, 0, 32'h43, 0, 32'h7FFF0000, 4'b1100, 32'h40, 0, 32'h00007FFF));
    vecs.push_back(mk(3'b010, 0, 0, 32'h6, 0, 32'h13572468, 4'b1111, 32'h4, 0, 32'h13572468));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata_o, 0);
    chk("rst err", 32'(err_o), 0);
    chk("rst req", 32'(bus_req_o), 0);
    chk("rst we", 32'(bus_we_o), 0);
    chk("rst addr", bus_addr_o, 0);
    chk("rst be", 32'(bus_be_o), 0);
    chk("rst wdata", bus_wdata_o, 0);
    chk("rst stall", 32'(stall_o), 0);
    rst_n = 1;
    step();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // LW with grant three cycles late and no response: timeout.
    funct3 = 3'b010; addr = 32'h8; memrd = 1;
    step();
    memrd = 0;
    chk("to req", 32'(bus_req_o), 1);
    n = 1;
    while (!err_o && stall_o && n < 100) begin
      bus_gnt = (n == 4);
      step();
      n++;
    end
    bus_gnt = 0;
    chk("to cycles", n, TO + 1);
    chk("to err", 32'(err_o), 1);
    chk("to rdata", rdata_o, 0);
    chk("to req_drop", 32'(bus_req_o), 0);
    chk("to stall", 32'(stall_o), 0);
    last_rd = 0;
    bus_rvalid = 1; bus_rdata = 32'h55555555;
    step();
    chk("late err", 32'(err_o), 0);
    chk("late rdata", rdata_o, 0);
    step();
    bus_rvalid = 0; bus_rdata = 0;
    chk("late rdata2", rdata_o, 0);
    chk("late stall", 32'(stall_o), 0);

    run_vec(vecs[4], 100);

    // LHU with a faulting response.
    funct3 = 3'b101; addr = 32'h11; memrd = 1;
    step();
    memrd = 0;
    chk("berr be", 32'(bus_be_o), 32'(4'b0011));
    chk("berr addr", bus_addr_o, 32'h10);
    bus_gnt = 1;
    step();
    bus_gnt = 0;
    bus_rvalid = 1; bus_err = 1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_rvalid = 0; bus_err = 0; bus_rdata = 0;
    chk("berr err", 32'(err_o), 1);
    chk("berr rdata", rdata_o, 0);
    chk("berr stall", 32'(stall_o), 0);
    last_rd = 0;
    step();
    chk("berr err_clr", 32'(err_o), 0);

    run_vec(vecs[0], 101);

    // Async reset while waiting for the response.
    funct3 = 3'b010; addr = 32'h44; memrd = 1;
    step();
    memrd = 0; bus_gnt = 1;
    step();
    bus_gnt = 0;
    chk("rw stall_wait", 32'(stall_o), 1);
    rst_n = 0;
    #1;
    chk("rw rdata", rdata_o, 0);
    chk("rw err", 32'(err_o), 0);
    chk("rw stall", 32'(stall_o), 0);
    chk("rw req", 32'(bus_req_o), 0);
    chk("rw be", 32'(bus_be_o), 0);
    step();
    rst_n = 1;
    last_rd = 0;
    step();
    chk("rw err_after", 32'(err_o), 0);
    run_vec(vecs[2], 102);

`ifdef LSU_MISALIGN_TRAP_EN
    funct3 = 3'b010; addr = 32'h6; memrd = 1;
    step();
    memrd = 0;
    chk("mis req", 32'(bus_req_o), 0);
    chk("mis stall", 32'(stall_o), 1);
    step();
    chk("mis err", 32'(err_o), 1);
    chk("mis rdata", rdata_o, 0);
    step();
    chk("mis err_clr", 32'(err_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, cycles after request before an unanswered bus access is abandoned (range 2..255).
- REQ-002 SHALL have these ports:
  - clk_i  in  1  clock, all state on rising edge.
  - rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
  - memrd_i  in  1  load request from control unit.
  - memw_i  in  1  store request from control unit.
  - funct3_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - addr_i  in  32  byte address (ALU result).
  - wdata_i  in  32  store data (rs2).
  - rdata_o  out  32  aligned, extended load data.
  - stall_o  out  1  hold pipeline.
  - err_o  out  1  one-cycle access-fault pulse.
  - bus_req_o  out  1  bus request.
  - bus_we_o  out  1  1 = write.
  - bus_addr_o  out  32  word address, bits [1:0] = 0.
  - bus_be_o  out  4  byte enables.
  - bus_wdata_o  out  32  lane-replicated store data.
  - bus_gnt_i  in  1  request accepted this cycle.
  - bus_rvalid_i  in  1  response valid, loads and stores.
  - bus_rdata_i  in  32  read word.
  - bus_err_i  in  1  fault, qualified by bus_rvalid_i.

Function
- REQ-003 SHALL implement FSM IDLE, REQ, WAIT, DONE.
- REQ-004 IDLE: memrd_i|memw_i SHALL latch addr, funct3, wdata and direction, then go to REQ; memw_i wins if both high.
- REQ-005 stall_o SHALL be combinational: 1 in IDLE with a request, in REQ and in WAIT; 0 in DONE and idle IDLE.
- REQ-006 REQ: bus_req_o=1 with latched fields; on bus_gnt_i go to WAIT and drop bus_req_o next cycle.
- REQ-007 WAIT: on bus_rvalid_i go to DONE; if bus_err_i also set, err_o=1 in DONE and rdata_o=0.
- REQ-008 DONE SHALL last exactly one cycle, ignore memrd_i/memw_i, then go to IDLE. Minimum access = 4 cycles with gnt and rvalid each 1 cycle after issue.
- REQ-009 bus_be_o SHALL be: B/BU 0001<<addr[1:0]; H/HU 0011<<(2*addr[1]); W 1111.
- REQ-010 bus_wdata_o SHALL replicate wdata[7:0] x4 for B, wdata[15:0] x2 for H, and pass wdata as-is for W.
- REQ-011 For loads, rdata_o SHALL take the selected lane and sign-extend it (B/H) or zero-extend it (BU/HU); W passes through.
- REQ-012 rdata_o SHALL register in the WAIT->DONE transition and hold until the next completed load. Stores SHALL leave rdata_o unchanged.
- REQ-013 A timeout counter SHALL clear on entering REQ and increment each REQ/WAIT cycle.
- REQ-014 On reaching TIMEOUT_CYC the unit SHALL go to DONE with err_o=1 and rdata_o=0; bus_req_o SHALL drop the same cycle.
- REQ-015 A response arriving after timeout SHALL be ignored.
- REQ-016 funct3 values 011, 110 and 111 SHALL be treated as W.

Reset
- REQ-017 On rst_ni low, asynchronously: state IDLE, counter 0, rdata_o=0, err_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_be_o=0, bus_wdata_o=0.
- REQ-018 Reset mid-access SHALL abandon the transaction without a pulse on err_o.

Configuration
- REQ-019 Macro LSU_MISALIGN_TRAP_EN: when defined, H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL skip the bus (no bus_req_o) and go IDLE->REQ->DONE with err_o=1 and rdata_o=0.
- REQ-020 When LSU_MISALIGN_TRAP_EN is undefined, low address bits not used by REQ-009 SHALL be ignored and the access issued normally.

Verification
- REQ-021 LB addr=0x103, bus_rdata=0x80xxxxxx -> be=1000, rdata_o=0xFFFFFF80, stall_o high 3 cycles.
- REQ-022 SH addr=0x202, wdata=0x1234ABCD -> be=1100, bus_wdata=0xABCDABCD, bus_we=1, bus_addr=0x200.
- REQ-023 LW with gnt delayed 3 cycles and rvalid never -> err_o pulse at cycle TIMEOUT_CYC, rdata_o=0, late rvalid ignored.
- REQ-024 LHU addr=0x11, rvalid with bus_err_i=1 -> err_o 1 cycle, rdata_o=0, FSM back to IDLE.
- REQ-025 LW addr=0x6: with macro, no bus_req_o and err_o=1; without macro, bus_addr=0x4 and be=1111.
- REQ-026 rst_ni low during WAIT -> all outputs 0 immediately, no err_o; next request completes normally.
